// File: rtl/apb_master_pkg.sv
// Shared types for the APB configuration master: FSM state encoding and the
// queued command record.
package apb_master_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Stored command; the master's ADDR_W/DATA_W must not exceed these widths.
  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for apb_cfg_master: DEPTH entries (power of two), wrap-around
// read/write pointers and an occupancy count driving the full/empty flags.
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  apb_cmd_t i_cmd,
  input  logic     i_pop,
  output apb_cmd_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  apb_cmd_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // NOTE: payload storage has no reset; pointers and count alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_cmd;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_cfg_master.sv
// APB configuration master: queued commands issued as SETUP/ACCESS transfers,
// one response pulse per transfer. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
module apb_cfg_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Pclk_i,
  input  logic              PReset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              PSel_o,
  output logic              PEnable_o,
  output logic              PWrite_o,
  output logic [ADDR_W-1:0] PAddr_o,
  output logic [DATA_W-1:0] PWData_o,
  input  logic [DATA_W-1:0] PRData_i,
  input  logic              PReady_i,
  input  logic              PSlvErr_i
);

  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  apb_cmd_t          w_push_cmd;
  apb_cmd_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_done;
  logic              w_abort;
  logic              w_finish;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  always_comb begin
    w_push_cmd                    = '0;
    w_push_cmd.write              = cmd_write_i;
    w_push_cmd.addr[ADDR_W-1:0]   = cmd_addr_i;
    w_push_cmd.wdata[DATA_W-1:0]  = cmd_wdata_i;
  end

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (Pclk_i),
    .i_rst   (PReset_i),
    .i_push  (cmd_valid_i),
    .i_cmd   (w_push_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts completed ACCESS cycles; cleared whenever the FSM leaves ACCESS.
  always_ff @(posedge Pclk_i or posedge PReset_i) begin
    if (PReset_i)                r_tmo_cnt <= '0;
    else if (r_state == ACCESS)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
    else                         r_tmo_cnt <= '0;
  end

  assign w_abort = (r_state == ACCESS) & ~PReady_i & (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYC;
  assign w_abort      = 1'b0;
`endif

  assign w_done   = (r_state == ACCESS) & PReady_i;
  assign w_finish = w_done | w_abort;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_finish) begin
          w_pop       = ~w_empty;
          w_state_nxt = w_empty ? IDLE : SETUP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Pclk_i or posedge PReset_i) begin
    if (PReset_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // APB outputs follow the next state so they are registered yet aligned with r_state.
  always_ff @(posedge Pclk_i or posedge PReset_i) begin
    if (PReset_i) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_psel    <= (w_state_nxt != IDLE);
      r_penable <= (w_state_nxt == ACCESS);
      if (w_pop) begin
        r_pwrite <= w_head.write;
        r_paddr  <= w_head.addr[ADDR_W-1:0];
        r_pwdata <= w_head.write ? w_head.wdata[DATA_W-1:0] : '0;
      end
    end
  end

  always_ff @(posedge Pclk_i or posedge PReset_i) begin
    if (PReset_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_finish;
      r_rsp_rdata <= (w_done & ~r_pwrite) ? PRData_i : '0;
      r_rsp_err   <= w_abort | (w_done & PSlvErr_i);
    end
  end

  assign cmd_ready_o = ~w_full;
  assign busy_o      = (r_state != IDLE) | ~w_empty;
  assign PSel_o      = r_psel;
  assign PEnable_o   = r_penable;
  assign PWrite_o    = r_pwrite;
  assign PAddr_o     = r_paddr;
  assign PWData_o    = r_pwdata;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: cycle-level protocol model with a scripted APB slave,
// directed scenarios, randomized traffic and mid-transfer reset.
module tb_apb_cfg_master;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 32;
  localparam int CMD_DEPTH   = 2;
  localparam int TIMEOUT_CYC = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              Pclk_i = 1'b0;
  logic              PReset_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              busy_o;
  logic              PSel_o;
  logic              PEnable_o;
  logic              PWrite_o;
  logic [ADDR_W-1:0] PAddr_o;
  logic [DATA_W-1:0] PWData_o;
  logic [DATA_W-1:0] PRData_i;
  logic              PReady_i;
  logic              PSlvErr_i;

  always #5 Pclk_i = ~Pclk_i;

  apb_cfg_master #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CMD_DEPTH   (CMD_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .Pclk_i      (Pclk_i),
    .PReset_i    (PReset_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .PSel_o      (PSel_o),
    .PEnable_o   (PEnable_o),
    .PWrite_o    (PWrite_o),
    .PAddr_o     (PAddr_o),
    .PWData_o    (PWData_o),
    .PRData_i    (PRData_i),
    .PReady_i    (PReady_i),
    .PSlvErr_i   (PSlvErr_i)
  );

  // One command plus the slave's scripted reply to it.
  typedef struct {
    bit        wr;
    bit [7:0]  addr;
    bit [31:0] wdata;
    int        waits;
    bit [31:0] rdata;
    bit        err;
  } txn_t;

  txn_t stim_q[$];
  txn_t cmd_q[$];
  txn_t cur;
  txn_t offered;
  int   phase;       // 0 idle, 1 setup, 2 access
  int   wait_left;
  int   acc_cycles;
  bit   drv_accept;
  bit   drv_ready;
  bit   rand_en;
  int   offer_pct;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit wr, input bit [7:0] a, input bit [31:0] d,
                              input int w, input bit [31:0] r, input bit e);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d; t.waits = w; t.rdata = r; t.err = e;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    return mk(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
              int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 7) == 0));
  endfunction

  task automatic model_reset();
    cmd_q.delete();
    stim_q.delete();
    phase      = 0;
    wait_left  = 0;
    acc_cycles = 0;
    drv_accept = 1'b0;
    drv_ready  = 1'b0;
  endtask

  // Advance the model over the edge just passed, compare, then drive the next cycle.
  task automatic step();
    bit        exp_rsp;
    bit        exp_err;
    bit [31:0] exp_rdata;
    @(negedge Pclk_i);
    exp_rsp = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    if (phase == 2) begin
      acc_cycles++;
      if (drv_ready) begin
        exp_rsp   = 1'b1;
        exp_rdata = cur.wr ? 32'h0 : cur.rdata;
        exp_err   = cur.err;
        phase     = 0;
      end else if (TMO_EN && acc_cycles == TIMEOUT_CYC) begin
        exp_rsp = 1'b1;
        exp_err = 1'b1;
        phase   = 0;
      end
    end else if (phase == 1) begin
      phase      = 2;
      acc_cycles = 0;
    end
    if (phase == 0 && cmd_q.size() > 0) begin
      cur       = cmd_q.pop_front();
      phase     = 1;
      wait_left = cur.waits;
    end
    if (drv_accept) cmd_q.push_back(offered);

    check("psel", 64'(PSel_o), 64'(phase != 0));
    check("penable", 64'(PEnable_o), 64'(phase == 2));
    if (phase != 0) begin
      check("paddr", 64'(PAddr_o), 64'(cur.addr));
      check("pwrite", 64'(PWrite_o), 64'(cur.wr));
      check("pwdata", 64'(PWData_o), cur.wr ? 64'(cur.wdata) : 64'h0);
    end
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rsp));
    if (exp_rsp) begin
      check("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
      check("rsp_err", 64'(rsp_err_o), 64'(exp_err));
    end
    check("cmd_ready", 64'(cmd_ready_o), 64'(cmd_q.size() < CMD_DEPTH));
    check("busy", 64'(busy_o), 64'(phase != 0 || cmd_q.size() != 0));

    if (phase == 2 && wait_left == 0) begin
      PReady_i  = 1'b1;
      PRData_i  = cur.rdata;
      PSlvErr_i = cur.err;
    end else begin
      if (phase == 2) wait_left--;
      PReady_i  = (phase == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      PRData_i  = $urandom;
      PSlvErr_i = 1'($urandom_range(0, 1));
    end
    drv_ready = (phase == 2) && PReady_i;

    if (stim_q.size() > 0) begin
      offered     = stim_q[0];
      cmd_valid_i = 1'b1;
    end else begin
      offered     = rand_txn();
      cmd_valid_i = rand_en && (int'($urandom_range(0, 99)) < offer_pct);
    end
    cmd_write_i = offered.wr;
    cmd_addr_i  = offered.addr;
    cmd_wdata_i = offered.wdata;
    drv_accept  = cmd_valid_i && (cmd_q.size() < CMD_DEPTH);
    if (drv_accept && stim_q.size() > 0) void'(stim_q.pop_front());
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while ((stim_q.size() > 0 || cmd_q.size() > 0 || phase != 0 || drv_accept) && left > 0) begin
      step();
      left--;
    end
    if (left == 0)
      check("drain_budget", 64'(phase + cmd_q.size() + stim_q.size()), 64'h0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_psel"},      64'(PSel_o),      64'h0);
    check({pfx, "_penable"},   64'(PEnable_o),   64'h0);
    check({pfx, "_pwrite"},    64'(PWrite_o),    64'h0);
    check({pfx, "_paddr"},     64'(PAddr_o),     64'h0);
    check({pfx, "_pwdata"},    64'(PWData_o),    64'h0);
    check({pfx, "_rsp_valid"}, 64'(rsp_valid_o), 64'h0);
    check({pfx, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'h0);
    check({pfx, "_rsp_err"},   64'(rsp_err_o),   64'h0);
    check({pfx, "_busy"},      64'(busy_o),      64'h0);
    check({pfx, "_cmd_ready"}, 64'(cmd_ready_o), 64'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int left;
    n_checks    = 0;
    n_fail      = 0;
    rand_en     = 1'b0;
    offer_pct   = 0;
    PReset_i    = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    PRData_i    = '0;
    PReady_i    = 1'b0;
    PSlvErr_i   = 1'b0;
    model_reset();

    #3;
    check_reset_outputs("por");
    @(negedge Pclk_i);
    PReset_i = 1'b0;

    // Single write, zero wait states.
    stim_q.push_back(mk(1'b1, 8'h00, 32'h0000_002F, 0, 32'h0, 1'b0));
    drain(50);
    // Read with three wait states.
    stim_q.push_back(mk(1'b0, 8'h04, 32'h0, 3, 32'h0000_003F, 1'b0));
    drain(50);
    // Three back-to-back commands, five wait states each.
    stim_q.push_back(mk(1'b1, 8'h10, 32'h1111_0001, 5, 32'h0, 1'b0));
    stim_q.push_back(mk(1'b0, 8'h14, 32'h0, 5, 32'hCAFE_0002, 1'b0));
    stim_q.push_back(mk(1'b1, 8'h18, 32'h3333_0003, 5, 32'h0, 1'b0));
    drain(100);
    // Slave error on a write.
    stim_q.push_back(mk(1'b1, 8'h20, 32'hDEAD_BEEF, 1, 32'h0, 1'b1));
    drain(50);
    // Long waits around the timeout boundary.
    stim_q.push_back(mk(1'b0, 8'h30, 32'h0, TIMEOUT_CYC - 1, 32'h1234_5678, 1'b0));
    stim_q.push_back(mk(1'b0, 8'h34, 32'h0, TIMEOUT_CYC, 32'h8765_4321, 1'b0));
    stim_q.push_back(mk(1'b1, 8'h38, 32'h5555_AAAA, 30, 32'h0, 1'b0));
    drain(300);

    // Randomized traffic at several offered loads.
    rand_en = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      offer_pct = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 100 : 50;
      repeat (500) step();
    end
    rand_en = 1'b0;
    drain(300);

    // Reset in the middle of ACCESS with one command still queued.
    stim_q.push_back(mk(1'b1, 8'h40, 32'hA5A5_A5A5, 12, 32'h0, 1'b0));
    stim_q.push_back(mk(1'b0, 8'h44, 32'h0, 0, 32'h0000_0001, 1'b0));
    left = 20;
    while (!(phase == 2 && cmd_q.size() == 1) && left > 0) begin
      step();
      left--;
    end
    check("rst_pre_penable", 64'(PEnable_o), 64'h1);
    check("rst_pre_busy", 64'(busy_o), 64'h1);
    #2;
    PReset_i    = 1'b1;
    cmd_valid_i = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge Pclk_i);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge Pclk_i);
    PReset_i = 1'b0;
    model_reset();
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cfg_master.md
APB_CFG_MASTER -- requirements
Module: apb_cfg_master

Interface
REQ-001 Parameter ADDR_W, 8, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width.
REQ-003 Parameter CMD_DEPTH, 2, command queue entries (power of two, >=2).
REQ-004 Parameter TIMEOUT_CYC, 16, maximum ACCESS cycles before abort (timeout build only).
REQ-005 Pclk_i  in  1  single clock; all state on rising edge.
REQ-006 PReset_i  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  command queue not full.
REQ-009 cmd_write_i  in  1  1 = write, 0 = read.
REQ-010 cmd_addr_i  in  ADDR_W  target address.
REQ-011 cmd_wdata_i  in  DATA_W  write data.
REQ-012 rsp_valid_o  out  1  one-cycle completion pulse, no backpressure.
REQ-013 rsp_rdata_o  out  DATA_W  read data (0 for writes).
REQ-014 rsp_err_o  out  1  slave error or timeout.
REQ-015 busy_o  out  1  queue non-empty or transfer in flight.
REQ-016 PSel_o, PEnable_o, PWrite_o  out  1 each  APB control.
REQ-017 PAddr_o  out  ADDR_W; PWData_o  out  DATA_W  APB address/data.
REQ-018 PRData_i  in  DATA_W; PReady_i  in  1; PSlvErr_i  in  1  APB slave response.

Function
REQ-019 Command SHALL be accepted on a cycle with cmd_valid_i & cmd_ready_o and pushed into the queue in order.
REQ-020 cmd_ready_o SHALL be low exactly when the queue holds CMD_DEPTH entries; push and pop in the same cycle SHALL leave the count unchanged.
REQ-021 FSM states SHALL be IDLE, SETUP, ACCESS; all APB outputs SHALL be registered.
REQ-022 IDLE: PSel_o=0, PEnable_o=0; queue non-empty -> pop head, SETUP next cycle.
REQ-023 SETUP: PSel_o=1, PEnable_o=0 for exactly one cycle -> ACCESS.
REQ-024 ACCESS: PSel_o=1, PEnable_o=1; held while PReady_i=0; completes on the edge where PReady_i=1.
REQ-025 PAddr_o, PWrite_o, PWData_o SHALL remain stable from SETUP until completion; PWData_o SHALL be 0 for reads.
REQ-026 On completion, rsp_valid_o SHALL be 1 for exactly the next cycle with rsp_rdata_o = captured PRData_i (reads) or 0 (writes), rsp_err_o = captured PSlvErr_i.
REQ-027 On completion with queue non-empty, FSM SHALL go directly to SETUP (no IDLE cycle); otherwise to IDLE.
REQ-028 A command pushed into an empty queue while IDLE SHALL produce PSel_o=1 two cycles after acceptance.
REQ-029 busy_o SHALL be 0 only when IDLE and queue empty.

Reset
REQ-030 PReset_i=1 SHALL immediately force IDLE, empty queue, all outputs 0 except cmd_ready_o=1.
REQ-031 Reset during SETUP/ACCESS SHALL abort the transfer with no rsp_valid_o pulse.

Configuration
REQ-032 With APB_MASTER_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; at TIMEOUT_CYC cycles with PReady_i=0 the transfer SHALL end, PSel_o/PEnable_o drop, rsp_valid_o pulses with rsp_err_o=1, rsp_rdata_o=0.
REQ-033 Without APB_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely and TIMEOUT_CYC SHALL have no effect.

Structure
REQ-034 Package apb_master_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the command struct (write, addr, wdata).
REQ-035 The queue SHALL be sub-module apb_cmd_fifo (CMD_DEPTH entries, wrap-around pointers, full/empty flags).

Verification
REQ-036 Write addr 0x00 data 0x2F, PReady_i tied 1 -> SETUP 1 cycle, ACCESS 1 cycle, PWData_o=0x2F, rsp_valid_o pulse, rsp_err_o=0.
REQ-037 Read addr 0x04, slave returns 0x3F after 3 wait cycles -> ACCESS lasts 4 cycles, rsp_rdata_o=0x3F.
REQ-038 Push 3 commands back-to-back, PReady_i=0 for 5 cycles -> cmd_ready_o low when 2 queued; transfers SETUP->ACCESS->SETUP without IDLE; responses in order.
REQ-039 Write with PSlvErr_i=1 on completion -> rsp_err_o=1.
REQ-040 APB_MASTER_TIMEOUT_EN, PReady_i held 0 -> abort after 16 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0.
REQ-041 Assert PReset_i mid-ACCESS with 1 queued command -> outputs 0 at once, no response, queue empty, busy_o=0 after release.
